fetch_predict: RTL and testbench
================================

FETCH_PREDICT -- requirements
Module: fetch_predict

Interface
REQ-001 The block SHALL have these parameters: RESET_PC, 32'h0000_0000, PC loaded on reset.
REQ-002 The block SHALL have this parameter: BHT_IDX, 4, index width of the branch history table (2**BHT_IDX entries, indexed by pc[BHT_IDX+1:2]).
REQ-003 The block SHALL have these ports:
- clk  input  1  clock; one clock, all state updates on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- pc  output  32  current fetch address to instruction memory.
- instr  input  32  instruction at pc, returned combinationally in the same cycle.
- s_IFID  input  1  1 = IF/ID advances; 0 = hold PC and IF/ID.
- b_IFID  input  1  1 = load a bubble into IF/ID.
- redirect_valid  input  1  mispredict or jump resolved in stage 4.
- redirect_pc  input  32  correct next fetch address.
- upd_valid  input  1  a resolved conditional branch trains the BHT this cycle.
- upd_pc  input  32  PC of that branch.
- upd_taken  input  1  actual branch outcome.
- pcs2  output  32  IF/ID PC.
- instrs2  output  32  IF/ID instruction.
- preds2  output  1  IF/ID predicted-taken flag.
- valids2  output  1  IF/ID holds a real instruction.

Function
REQ-004 The block SHALL classify instr combinationally: JAL is opcode 7'b1101111; conditional branch is opcode 7'b1100011.
REQ-005 For a JAL, predicted next PC SHALL be pc + sign-extended J-immediate, and the predicted-taken flag SHALL be 1.
REQ-006 For a conditional branch, the block SHALL read BHT[pc[BHT_IDX+1:2]]; if the counter is >= 2, predicted next PC SHALL be pc + sign-extended B-immediate with flag 1, else pc+4 with flag 0.
REQ-007 All other opcodes SHALL predict pc+4 with flag 0; all PC arithmetic SHALL be 32-bit modulo 2**32 (wrap, no overflow detection).
REQ-008 The PC update priority, highest first, SHALL be: rst -> RESET_PC; redirect_valid -> redirect_pc; s_IFID==0 -> hold; otherwise -> predicted next PC.
REQ-009 The IF/ID update priority, highest first, SHALL be: rst -> bubble; b_IFID -> bubble; s_IFID==0 -> hold; otherwise load {pc, instr, flag, valid=1}.
REQ-010 A bubble SHALL be: pcs2=0, instrs2=32'h0000_0013 (NOP), preds2=0, valids2=0.
REQ-011 redirect_valid with b_IFID=0 SHALL still load redirect_pc into PC; IF/ID then follows REQ-009.
REQ-012 b_IFID=1 with s_IFID=0 SHALL yield a bubble, since bubble dominates hold.
REQ-013 BHT entries SHALL be 2-bit saturating counters.
REQ-014 When upd_valid=1 and rst=0, BHT[upd_pc[BHT_IDX+1:2]] SHALL increment if upd_taken=1 (saturating at 3), otherwise decrement (saturating at 0), on the next edge.
REQ-015 BHT updates SHALL be independent of s_IFID, b_IFID and redirect_valid.
REQ-016 When the BHT read and the BHT update hit the same entry in the same cycle, the prediction SHALL use the pre-update value.
REQ-017 Latency: pc SHALL appear in pcs2 one cycle after fetch; there SHALL be no fetch-side stall of its own, and instr is always valid.

Reset
REQ-018 On rst=1 at a rising edge: pc=RESET_PC; IF/ID = bubble; every BHT entry = 2'b01 (weakly not-taken).
REQ-019 rst SHALL override redirect, stall, bubble and BHT update in the same cycle.
REQ-020 Reset asserted mid-stall or mid-redirect SHALL leave no residual state.

Verification
REQ-021 Reset, then straight-line code: instr=ADDI each cycle -> pc 0,4,8,...; pcs2 lags by one cycle; valids2=1 from the second edge.
REQ-022 Branch BEQ at pc=0x10 with imm=+0x20: untrained -> next pc=0x14, preds2=0; after two upd_taken=1 updates at upd_pc=0x10 -> next pc=0x30, preds2=1.
REQ-023 Stall: s_IFID=0 for 3 cycles at pc=0x8 -> pc stays 0x8 and the IF/ID contents are unchanged; on release, pcs2=0x8.
REQ-024 Redirect: redirect_valid=1, redirect_pc=0x100, b_IFID=1, s_IFID=0 simultaneously -> next pc=0x100 and IF/ID bubble (instrs2=0x13, valids2=0).
REQ-025 Saturation and collision: four upd_taken=1 updates then one upd_taken=0 -> counter 3 then 2, still predicts taken; an update and a read of the same entry in the same cycle predict from the old value.
REQ-026 JAL at pc=0xFFFF_FFFC with imm=+8 -> next pc=0x0000_0004 (wrap), preds2=1.

Source files
------------

// File: rtl/fetch_predict.sv
// Instruction fetch stage with static JAL prediction and a 2-bit BHT for
// conditional branches, feeding a stallable / flushable IF/ID register.
module fetch_predict #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          BHT_IDX  = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        s_IFID,
    input  logic        b_IFID,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    output logic [31:0] pcs2,
    output logic [31:0] instrs2,
    output logic        preds2,
    output logic        valids2
);

    localparam int          BHT_N = 1 << BHT_IDX;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [1:0]         bht [BHT_N];
    logic               is_jal, is_br;
    logic [31:0]        j_imm, b_imm;
    logic [BHT_IDX-1:0] rd_idx, up_idx;
    logic [1:0]         rd_ctr;
    logic [31:0]        next_pc;
    logic               pred;
    logic               unused_upd_bits;

    assign unused_upd_bits = ^{upd_pc[31:BHT_IDX+2], upd_pc[1:0]};

    assign is_jal = (instr[6:0] == 7'b1101111);
    assign is_br  = (instr[6:0] == 7'b1100011);
    assign j_imm  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign b_imm  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign rd_idx = pc[BHT_IDX+1:2];
    assign up_idx = upd_pc[BHT_IDX+1:2];
    // Read happens before this edge's write, so a colliding update is not seen.
    assign rd_ctr = bht[rd_idx];

    always_comb begin
        next_pc = pc + 32'd4;
        pred    = 1'b0;
        if (is_jal) begin
            next_pc = pc + j_imm;
            pred    = 1'b1;
        end else if (is_br && rd_ctr[1]) begin
            next_pc = pc + b_imm;
            pred    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            pcs2    <= 32'd0;
            instrs2 <= NOP;
            preds2  <= 1'b0;
            valids2 <= 1'b0;
        end else begin
            if (redirect_valid)
                pc <= redirect_pc;
            else if (s_IFID)
                pc <= next_pc;

            if (b_IFID) begin
                pcs2    <= 32'd0;
                instrs2 <= NOP;
                preds2  <= 1'b0;
                valids2 <= 1'b0;
            end else if (s_IFID) begin
                pcs2    <= pc;
                instrs2 <= instr;
                preds2  <= pred;
                valids2 <= 1'b1;
            end
        end
    end

    // Training is decoupled from pipeline control; only reset suppresses it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_N; i++)
                bht[i] <= 2'b01;
        end else if (upd_valid) begin
            if (upd_taken && bht[up_idx] != 2'b11)
                bht[up_idx] <= bht[up_idx] + 2'b01;
            else if (!upd_taken && bht[up_idx] != 2'b00)
                bht[up_idx] <= bht[up_idx] - 2'b01;
        end
    end

endmodule

// File: tb/tb_fetch_predict.sv
// Directed vector table for fetch_predict, followed by randomized traffic
// checked against a cycle-level reference model.
module tb_fetch_predict;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] ADI = 32'h0010_0093;
    localparam logic [31:0] BEQ = 32'h0200_0063;
    localparam logic [31:0] JAL = 32'h0080_006F;

    logic        clk = 1'b0;
    logic        rst, s_IFID, b_IFID, redirect_valid, upd_valid, upd_taken;
    logic [31:0] redirect_pc, upd_pc, instr;
    logic [31:0] pc, pcs2, instrs2;
    logic        preds2, valids2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_predict #(.RESET_PC(32'h0), .BHT_IDX(4)) dut (
        .clk(clk), .rst(rst), .pc(pc), .instr(instr),
        .s_IFID(s_IFID), .b_IFID(b_IFID),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .pcs2(pcs2), .instrs2(instrs2), .preds2(preds2), .valids2(valids2)
    );

    typedef struct {
        logic        rst, s, b, rv;
        logic [31:0] rpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] instr;
        logic [31:0] e_pc, e_pcs2, e_instrs2;
        logic        e_p, e_v;
    } vec_t;

    function automatic vec_t mk(input logic r, s, b, rv, input logic [31:0] rpc,
                                input logic uv, input logic [31:0] upc, input logic ut,
                                input logic [31:0] ins, e_pc, e_pcs2, e_ins,
                                input logic e_p, e_v);
        vec_t v;
        v.rst = r; v.s = s; v.b = b; v.rv = rv; v.rpc = rpc;
        v.uv = uv; v.upc = upc; v.ut = ut; v.instr = ins;
        v.e_pc = e_pc; v.e_pcs2 = e_pcs2; v.e_instrs2 = e_ins; v.e_p = e_p; v.e_v = e_v;
        return v;
    endfunction

    task automatic check(input string name, input int cyc, input logic [31:0] act, exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic r, s, b, rv, input logic [31:0] rpc,
                         input logic uv, input logic [31:0] upc, input logic ut,
                         input logic [31:0] ins);
        rst = r; s_IFID = s; b_IFID = b; redirect_valid = rv; redirect_pc = rpc;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; instr = ins;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input int cyc, input logic [31:0] e_pc, e_pcs2, e_ins,
                             input logic e_p, e_v);
        check("pc",      cyc, pc,      e_pc);
        check("pcs2",    cyc, pcs2,    e_pcs2);
        check("instrs2", cyc, instrs2, e_ins);
        check("preds2",  cyc, {31'd0, preds2},  {31'd0, e_p});
        check("valids2", cyc, {31'd0, valids2}, {31'd0, e_v});
    endtask

    // Reference model: architectural state kept as plain integers.
    logic [31:0] m_pc, m_pcs2, m_ins;
    logic        m_p, m_v;
    int          m_bht [16];

    function automatic logic [31:0] ref_next(input logic [31:0] p, ins,
                                             input int ctr, output logic tk);
        longint imm;
        tk = 1'b0;
        imm = 4;
        if (ins[6:0] == 7'b1101111) begin
            imm = (ins[31] ? -1048576 : 0) + longint'(ins[19:12]) * 4096
                + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
            tk = 1'b1;
        end else if (ins[6:0] == 7'b1100011 && ctr >= 2) begin
            imm = (ins[31] ? -4096 : 0) + longint'(ins[7]) * 2048
                + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
            tk = 1'b1;
        end
        return 32'((longint'(p) + imm) % 64'sh1_0000_0000);
    endfunction

    task automatic model_step(input logic r, s, b, rv, input logic [31:0] rpc,
                              input logic uv, input logic [31:0] upc, input logic ut,
                              input logic [31:0] ins);
        logic        tk;
        logic [31:0] np;
        np = ref_next(m_pc, ins, m_bht[(m_pc / 4) % 16], tk);
        if (r) begin
            m_pc = 32'h0; m_pcs2 = 0; m_ins = NOP; m_p = 0; m_v = 0;
            for (int i = 0; i < 16; i++) m_bht[i] = 1;
        end else begin
            if (b) begin
                m_pcs2 = 0; m_ins = NOP; m_p = 0; m_v = 0;
            end else if (s) begin
                m_pcs2 = m_pc; m_ins = ins; m_p = tk; m_v = 1;
            end
            if (rv) m_pc = rpc;
            else if (s) m_pc = np;
            if (uv) begin
                if (ut) m_bht[(upc / 4) % 16] = (m_bht[(upc / 4) % 16] == 3) ? 3 : m_bht[(upc / 4) % 16] + 1;
                else    m_bht[(upc / 4) % 16] = (m_bht[(upc / 4) % 16] == 0) ? 0 : m_bht[(upc / 4) % 16] - 1;
            end
        end
    endtask

    initial begin
        vec_t vec[$];
        // rst s b rv rpc uv upc ut instr | pc pcs2 instrs2 pred valid
        vec.push_back(mk(1,1,0,0,0,    0,0,0, NOP, 32'h00, 32'h00, NOP, 0,0)); // reset
        vec.push_back(mk(0,1,0,0,0,    0,0,0, ADI, 32'h04, 32'h00, ADI, 0,1));
        vec.push_back(mk(0,1,0,0,0,    0,0,0, ADI, 32'h08, 32'h04, ADI, 0,1));
        vec.push_back(mk(0,0,0,0,0,    0,0,0, ADI, 32'h08, 32'h04, ADI, 0,1)); // stall x3
        vec.push_back(mk(0,0,0,0,0,    0,0,0, ADI, 32'h08, 32'h04, ADI, 0,1));
        vec.push_back(mk(0,0,0,0,0,    0,0,0, ADI, 32'h08, 32'h04, ADI, 0,1));
        vec.push_back(mk(0,1,0,0,0,    0,0,0, ADI, 32'h0C, 32'h08, ADI, 0,1));
        vec.push_back(mk(0,1,0,0,0,    0,0,0, ADI, 32'h10, 32'h0C, ADI, 0,1));
        vec.push_back(mk(0,1,0,0,0,    0,0,0, BEQ, 32'h14, 32'h10, BEQ, 0,1)); // untrained
        vec.push_back(mk(0,1,1,1,32'h10, 0,0,0, ADI, 32'h10, 32'h00, NOP, 0,0));
        vec.push_back(mk(0,1,0,0,0,    1,32'h10,1, BEQ, 32'h14, 32'h10, BEQ, 0,1)); // collision 1->2
        vec.push_back(mk(0,1,1,1,32'h10, 1,32'h10,1, ADI, 32'h10, 32'h00, NOP, 0,0));
        vec.push_back(mk(0,1,0,0,0,    0,0,0, BEQ, 32'h30, 32'h10, BEQ, 1,1)); // trained
        vec.push_back(mk(0,1,1,1,32'h10, 1,32'h10,1, ADI, 32'h10, 32'h00, NOP, 0,0));
        vec.push_back(mk(0,0,1,0,0,    1,32'h10,1, BEQ, 32'h10, 32'h00, NOP, 0,0)); // bubble beats hold
        vec.push_back(mk(0,0,0,0,0,    1,32'h10,0, BEQ, 32'h10, 32'h00, NOP, 0,0)); // 3 -> 2
        vec.push_back(mk(0,1,0,0,0,    0,0,0, BEQ, 32'h30, 32'h10, BEQ, 1,1));
        vec.push_back(mk(0,0,1,1,32'h100, 0,0,0, ADI, 32'h100, 32'h00, NOP, 0,0));
        vec.push_back(mk(0,1,1,1,32'hFFFF_FFFC, 0,0,0, ADI, 32'hFFFF_FFFC, 32'h00, NOP, 0,0));
        vec.push_back(mk(0,1,0,0,0,    0,0,0, JAL, 32'h04, 32'hFFFF_FFFC, JAL, 1,1)); // wrap
        vec.push_back(mk(1,0,0,1,32'h200, 1,32'h10,0, JAL, 32'h00, 32'h00, NOP, 0,0)); // rst wins
        vec.push_back(mk(0,1,1,1,32'h10, 0,0,0, ADI, 32'h10, 32'h00, NOP, 0,0));
        vec.push_back(mk(0,1,0,0,0,    0,0,0, BEQ, 32'h14, 32'h10, BEQ, 0,1)); // BHT re-init

        foreach (vec[k]) begin
            drive(vec[k].rst, vec[k].s, vec[k].b, vec[k].rv, vec[k].rpc,
                  vec[k].uv, vec[k].upc, vec[k].ut, vec[k].instr);
            check_all(k, vec[k].e_pc, vec[k].e_pcs2, vec[k].e_instrs2, vec[k].e_p, vec[k].e_v);
        end

        // Randomized phase; model starts from a reset applied to both.
        model_step(1, 1, 0, 0, 0, 0, 0, 0, NOP);
        drive(1, 1, 0, 0, 0, 0, 0, 0, NOP);
        check_all(1000, m_pc, m_pcs2, m_ins, m_p, m_v);
        for (int c = 0; c < 600; c++) begin
            logic        r, s, b, rv, uv, ut;
            logic [31:0] rpc, upc, ins;
            r   = ($urandom % 64) == 0;
            s   = ($urandom % 4) != 0;
            b   = ($urandom % 8) == 0;
            rv  = ($urandom % 6) == 0;
            rpc = (($urandom % 8) == 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom_range(0, 255) * 4;
            uv  = ($urandom % 2) == 0;
            upc = $urandom_range(0, 255) * 4;
            ut  = ($urandom % 3) != 0;
            ins = $urandom;
            case ($urandom % 3)
                0: ins[6:0] = 7'b1101111;
                1: ins[6:0] = 7'b1100011;
                default: ins[6:0] = 7'b0010011;
            endcase
            model_step(r, s, b, rv, rpc, uv, upc, ut, ins);
            drive(r, s, b, rv, rpc, uv, upc, ut, ins);
            check_all(1001 + c, m_pc, m_pcs2, m_ins, m_p, m_v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
